// File: rtl/branch_comp_iter.sv
// Multi-cycle RV32I branch comparator: walks operand slices MSB-first
// and registers the branch decision on entry to DONE.
module branch_comp_iter #(
  parameter int XLEN       = 32,
  parameter int SLICE      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            branch,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_taken
);

  localparam int NSLICE = XLEN / SLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KTOP = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      f3_q;
  logic [KW-1:0]   k, k_n;
  logic            decided, decided_n;
  logic            lt, lt_n;
  logic            taken, taken_n;

  logic [SLICE-1:0] sa, sb, sa_x, sb_x;
  logic             sgn, hit, dec_x, lt_x, res;
  logic             accept, bypass;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign br_taken  = taken;

  assign accept = in_ready && in_valid && !flush;
  // Non-branches and the unused 010/011 encodings never compare
  assign bypass = !branch || (funct3[2:1] == 2'b01);

  always_comb begin
    sa   = a_q[k*SLICE +: SLICE];
    sb   = b_q[k*SLICE +: SLICE];
    sgn  = (k == KTOP) && (f3_q[2:1] == 2'b10);
    sa_x = sa;
    sb_x = sb;
    // Flip sign bits so an unsigned compare orders two's complement
    sa_x[SLICE-1] = sa[SLICE-1] ^ sgn;
    sb_x[SLICE-1] = sb[SLICE-1] ^ sgn;
    hit   = !decided && (sa != sb);
    dec_x = decided || hit;
    lt_x  = hit ? (sa_x < sb_x) : lt;
  end

  always_comb begin
    res = 1'b0;
    unique case (1'b1)
      (f3_q == 3'b000):     res = !dec_x;
      (f3_q == 3'b001):     res = dec_x;
      (f3_q[2:1] == 2'b10),
      (f3_q[2:1] == 2'b11): res = f3_q[0] ? !lt_x : lt_x;
      default:              res = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    k_n       = k;
    decided_n = decided;
    lt_n      = lt;
    taken_n   = taken;
    if (flush) begin
      state_n = IDLE;
      taken_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (bypass) begin
              state_n = DONE;
              taken_n = 1'b0;
            end else begin
              state_n   = RUN;
              k_n       = KTOP;
              decided_n = 1'b0;
              lt_n      = 1'b0;
            end
          end
        end
        RUN: begin
          decided_n = dec_x;
          lt_n      = lt_x;
          if (k == '0 || (EARLY_EXIT != 0 && hit)) begin
            state_n = DONE;
            taken_n = res;
          end else begin
            k_n = k - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_n = IDLE;
            taken_n = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
          taken_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      decided <= 1'b0;
      lt      <= 1'b0;
      taken   <= 1'b0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      decided <= decided_n;
      lt      <= lt_n;
      taken   <= taken_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      f3_q <= '0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      f3_q <= funct3;
    end
  end

endmodule
